// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared bus state codes and port encodings for the RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    typedef enum logic [1:0] {
        BUS_IDLE      = 2'd0,
        BUS_WAIT_INST = 2'd1,
        BUS_WAIT_LOAD = 2'd2,
        BUS_DBG       = 2'd3
    } bus_state_e;

    localparam logic BUS_PORT_IF = 1'b0;
    localparam logic BUS_PORT_LS = 1'b1;

endpackage
`default_nettype wire

// File: rtl/bus_lat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : bus_lat_cnt
// Description : RAM read-latency counter; loads MEM_LAT-1, counts down to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_lat_cnt #(
    parameter int MEM_LAT = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic done
);

    localparam int              c_cnt_w    = $clog2(MEM_LAT + 1);
    localparam logic [c_cnt_w-1:0] c_load_val = c_cnt_w'(MEM_LAT - 1);

    logic [c_cnt_w-1:0] r_count;

    // Saturates at zero so a stalled wait never wraps into a bogus long count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= c_load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - c_cnt_w'(1);
        end
    end

    assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/bus_arb.sv
`default_nettype none
// ============================================================================
// Module      : bus_arb
// Description : Arbitrates fetch, load/store and debug writes onto one RAM port.
//               Define BUS_ARB_RR_EN for round-robin fetch/load-store priority.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                dbg_wen,
    input  logic [ADDR_W-1:0]   dbg_addr,
    input  logic [DATA_W-1:0]   dbg_wdata,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [DATA_W/8-1:0] ls_wbmask,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_wen,
    output logic [DATA_W/8-1:0] mem_wbmask,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [1:0]          bus_state
);

    import bus_pkg::*;

    bus_state_e        r_state;
    bus_state_e        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_if_rvalid;
    logic              r_ls_rvalid;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_ls_rdata;

    logic w_arb_ok;
    logic w_if_gnt;
    logic w_ls_gnt;
    logic w_rd_gnt;
    logic w_st_gnt;
    logic w_wait;
    logic w_done;
    logic w_if_fin;
    logic w_ls_fin;

    assign w_arb_ok = (r_state == BUS_IDLE) && !dbg_wen;

`ifdef BUS_ARB_RR_EN
    logic r_last;

    always_comb begin
        w_if_gnt = 1'b0;
        w_ls_gnt = 1'b0;
        if (w_arb_ok) begin
            if (if_req && ls_req) begin
                w_ls_gnt = (r_last == BUS_PORT_IF);
                w_if_gnt = (r_last == BUS_PORT_LS);
            end else begin
                w_if_gnt = if_req;
                w_ls_gnt = ls_req;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last <= BUS_PORT_LS;
        end else if (w_if_gnt) begin
            r_last <= BUS_PORT_IF;
        end else if (w_ls_gnt) begin
            r_last <= BUS_PORT_LS;
        end
    end
`else
    assign w_ls_gnt = w_arb_ok && ls_req;
    assign w_if_gnt = w_arb_ok && if_req && !ls_req;
`endif

    assign w_rd_gnt = w_if_gnt || (w_ls_gnt && !ls_we);
    assign w_st_gnt = w_ls_gnt && ls_we;
    assign w_wait   = (r_state == BUS_WAIT_INST) || (r_state == BUS_WAIT_LOAD);

    // A debug write on the final wait cycle still aborts the read
    assign w_if_fin = (r_state == BUS_WAIT_INST) && w_done && !dbg_wen;
    assign w_ls_fin = (r_state == BUS_WAIT_LOAD) && w_done && !dbg_wen;

    bus_lat_cnt #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_cnt (
        .clock (clock),
        .reset (reset),
        .load  (w_rd_gnt),
        .dec   (w_wait),
        .done  (w_done)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            BUS_IDLE: begin
                if (w_if_gnt) begin
                    w_next = BUS_WAIT_INST;
                end else if (w_ls_gnt && !ls_we) begin
                    w_next = BUS_WAIT_LOAD;
                end
            end
            BUS_WAIT_INST,
            BUS_WAIT_LOAD: begin
                if (w_done) begin
                    w_next = BUS_IDLE;
                end
            end
            default: begin
                w_next = BUS_IDLE;
            end
        endcase
        if (dbg_wen) begin
            w_next = BUS_DBG;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= BUS_IDLE;
            r_addr      <= '0;
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
        end else begin
            r_state     <= w_next;
            r_if_rvalid <= w_if_fin;
            r_ls_rvalid <= w_ls_fin;
            if (w_rd_gnt) begin
                r_addr <= w_if_gnt ? if_addr : ls_addr;
            end
            if (w_if_fin) begin
                r_if_rdata <= mem_rdata;
            end
            if (w_ls_fin) begin
                r_ls_rdata <= mem_rdata;
            end
        end
    end

    // The registered address keeps the RAM address stable for the whole wait
    always_comb begin
        mem_wen    = 1'b0;
        mem_wbmask = '0;
        mem_addr   = r_addr;
        mem_wdata  = '0;
        if (dbg_wen) begin
            mem_wen    = 1'b1;
            mem_wbmask = '1;
            mem_addr   = dbg_addr;
            mem_wdata  = dbg_wdata;
        end else if (w_st_gnt) begin
            mem_wen    = 1'b1;
            mem_wbmask = ls_wbmask;
            mem_addr   = ls_addr;
            mem_wdata  = ls_wdata;
        end else if (w_if_gnt) begin
            mem_addr = if_addr;
        end else if (w_ls_gnt) begin
            mem_addr = ls_addr;
        end
    end

    assign if_gnt    = w_if_gnt;
    assign ls_gnt    = w_ls_gnt;
    assign if_rvalid = r_if_rvalid;
    assign ls_rvalid = r_ls_rvalid;
    assign if_rdata  = r_if_rdata;
    assign ls_rdata  = r_ls_rdata;
    assign bus_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_bus_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arb
// Description : Directed self-checking bench; one arbiter at MEM_LAT=1, one at 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arb;

    logic        clock = 1'b0;
    logic        reset;
    logic        dbg_wen;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req, ls_we;
    logic [3:0]  ls_wbmask;
    logic [31:0] ls_addr, ls_wdata;

    logic        a_if_gnt, a_if_rvalid, a_ls_gnt, a_ls_rvalid, a_mem_wen;
    logic [31:0] a_if_rdata, a_ls_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [3:0]  a_mem_wbmask;
    logic [1:0]  a_bus_state;
    logic        b_if_gnt, b_if_rvalid, b_ls_gnt, b_ls_rvalid, b_mem_wen;
    logic [31:0] b_if_rdata, b_ls_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_mem_wbmask;
    logic [1:0]  b_bus_state;

    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    logic [31:0] b_pipe1, b_pipe2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    bus_arb #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_a (
        .clock(clock), .reset(reset),
        .dbg_wen(dbg_wen), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .if_req(if_req), .if_addr(if_addr),
        .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_wbmask(ls_wbmask), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(a_ls_gnt), .ls_rvalid(a_ls_rvalid), .ls_rdata(a_ls_rdata),
        .mem_wen(a_mem_wen), .mem_wbmask(a_mem_wbmask), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata), .bus_state(a_bus_state)
    );

    bus_arb #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut_b (
        .clock(clock), .reset(reset),
        .dbg_wen(dbg_wen), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .if_req(if_req), .if_addr(if_addr),
        .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_wbmask(ls_wbmask), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(b_ls_gnt), .ls_rvalid(b_ls_rvalid), .ls_rdata(b_ls_rdata),
        .mem_wen(b_mem_wen), .mem_wbmask(b_mem_wbmask), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .bus_state(b_bus_state)
    );

    // Byte-masked RAM models with 1-cycle and 3-cycle read latency
    always @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (a_mem_wen && a_mem_wbmask[i]) mem_a[a_mem_addr[9:2]][8*i +: 8] <= a_mem_wdata[8*i +: 8];
            if (b_mem_wen && b_mem_wbmask[i]) mem_b[b_mem_addr[9:2]][8*i +: 8] <= b_mem_wdata[8*i +: 8];
        end
        a_mem_rdata <= mem_a[a_mem_addr[9:2]];
        b_pipe1     <= mem_b[b_mem_addr[9:2]];
        b_pipe2     <= b_pipe1;
        b_mem_rdata <= b_pipe2;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        dbg_wen = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_wbmask = '0; ls_addr = '0; ls_wdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic dbg_load(input logic [31:0] addr, input logic [31:0] data);
        tick();
        dbg_wen = 1'b1; dbg_addr = addr; dbg_wdata = data;
        tick();
        dbg_wen = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_checks++; if (a_bus_state !== 2'd0) $display("FAIL rst_state: got %0d want 0", a_bus_state); else n_pass++;
        n_checks++; if (b_bus_state !== 2'd0) $display("FAIL rst_state_b: got %0d want 0", b_bus_state); else n_pass++;
        n_checks++; if (a_if_rvalid !== 1'b0) $display("FAIL rst_if_rvalid: got %b want 0", a_if_rvalid); else n_pass++;
        n_checks++; if (a_ls_rvalid !== 1'b0) $display("FAIL rst_ls_rvalid: got %b want 0", a_ls_rvalid); else n_pass++;
        n_checks++; if (a_if_rdata !== 32'h0) $display("FAIL rst_if_rdata: got %h want 0", a_if_rdata); else n_pass++;
        n_checks++; if (a_ls_rdata !== 32'h0) $display("FAIL rst_ls_rdata: got %h want 0", a_ls_rdata); else n_pass++;
        n_checks++; if (a_mem_wen !== 1'b0) $display("FAIL rst_mem_wen: got %b want 0", a_mem_wen); else n_pass++;
        reset = 1'b1;
    endtask

    task automatic test_fetch();
        do_reset();
        dbg_load(32'h0, 32'h0010_0093);
        tick(); if_req = 1'b1; if_addr = 32'h0;
        @(negedge clock);
        n_checks++; if (a_if_gnt !== 1'b1) $display("FAIL fetch_gnt: got %b want 1", a_if_gnt); else n_pass++;
        n_checks++; if (a_ls_gnt !== 1'b0) $display("FAIL fetch_ls_gnt: got %b want 0", a_ls_gnt); else n_pass++;
        n_checks++; if (a_mem_addr !== 32'h0) $display("FAIL fetch_addr: got %h want 0", a_mem_addr); else n_pass++;
        tick(); if_req = 1'b0;
        @(negedge clock);
        n_checks++; if (a_bus_state !== 2'd1) $display("FAIL fetch_wait_state: got %0d want 1", a_bus_state); else n_pass++;
        n_checks++; if (a_if_rvalid !== 1'b0) $display("FAIL fetch_early_rvalid: got %b want 0", a_if_rvalid); else n_pass++;
        tick();
        @(negedge clock);
        n_checks++; if (a_if_rvalid !== 1'b1) $display("FAIL fetch_rvalid: got %b want 1", a_if_rvalid); else n_pass++;
        n_checks++; if (a_if_rdata !== 32'h0010_0093) $display("FAIL fetch_rdata: got %h want 00100093", a_if_rdata); else n_pass++;
        n_checks++; if (a_bus_state !== 2'd0) $display("FAIL fetch_idle: got %0d want 0", a_bus_state); else n_pass++;
        tick();
        @(negedge clock);
        n_checks++; if (a_if_rvalid !== 1'b0) $display("FAIL fetch_rvalid_pulse: got %b want 0", a_if_rvalid); else n_pass++;
        n_checks++; if (a_if_rdata !== 32'h0010_0093) $display("FAIL fetch_rdata_hold: got %h want 00100093", a_if_rdata); else n_pass++;
    endtask

    task automatic test_store();
        do_reset();
        dbg_load(32'h40, 32'h1122_3344);
        tick(); ls_req = 1'b1; ls_we = 1'b1; ls_wbmask = 4'b0011; ls_addr = 32'h40; ls_wdata = 32'hAABB_CCDD;
        @(negedge clock);
        n_checks++; if (a_ls_gnt !== 1'b1) $display("FAIL store_gnt: got %b want 1", a_ls_gnt); else n_pass++;
        n_checks++; if (a_mem_wen !== 1'b1) $display("FAIL store_wen: got %b want 1", a_mem_wen); else n_pass++;
        n_checks++; if (a_mem_wbmask !== 4'b0011) $display("FAIL store_mask: got %b want 0011", a_mem_wbmask); else n_pass++;
        n_checks++; if (a_mem_addr !== 32'h40) $display("FAIL store_addr: got %h want 40", a_mem_addr); else n_pass++;
        n_checks++; if (a_mem_wdata !== 32'hAABB_CCDD) $display("FAIL store_wdata: got %h want aabbccdd", a_mem_wdata); else n_pass++;
        tick(); ls_we = 1'b0;
        @(negedge clock);
        n_checks++; if (a_bus_state !== 2'd0) $display("FAIL store_stays_idle: got %0d want 0", a_bus_state); else n_pass++;
        n_checks++; if (a_ls_rvalid !== 1'b0) $display("FAIL store_no_rvalid: got %b want 0", a_ls_rvalid); else n_pass++;
        n_checks++; if (a_ls_gnt !== 1'b1) $display("FAIL load_gnt: got %b want 1", a_ls_gnt); else n_pass++;
        n_checks++; if (a_mem_wen !== 1'b0) $display("FAIL load_wen: got %b want 0", a_mem_wen); else n_pass++;
        tick(); ls_req = 1'b0;
        @(negedge clock);
        n_checks++; if (a_bus_state !== 2'd2) $display("FAIL load_wait_state: got %0d want 2", a_bus_state); else n_pass++;
        tick();
        @(negedge clock);
        n_checks++; if (a_ls_rvalid !== 1'b1) $display("FAIL load_rvalid: got %b want 1", a_ls_rvalid); else n_pass++;
        n_checks++; if (a_ls_rdata[15:0] !== 16'hCCDD) $display("FAIL load_low_half: got %h want ccdd", a_ls_rdata[15:0]); else n_pass++;
        n_checks++; if (a_ls_rdata !== 32'h1122_CCDD) $display("FAIL load_word: got %h want 1122ccdd", a_ls_rdata); else n_pass++;
    endtask

    task automatic test_arb();
        logic [5:0] exp_if;
        logic [5:0] exp_ls;
        logic       exp_if_rv2;
`ifdef BUS_ARB_RR_EN
        exp_if = 6'b010001; exp_ls = 6'b000100; exp_if_rv2 = 1'b1;
`else
        exp_if = 6'b000000; exp_ls = 6'b010101; exp_if_rv2 = 1'b0;
`endif
        do_reset();
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 0) begin
                if_req = 1'b1; if_addr = 32'h0; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40;
            end
            @(negedge clock);
            n_checks++; if (a_if_gnt !== exp_if[c]) $display("FAIL arb_if_gnt c%0d: got %b want %b", c, a_if_gnt, exp_if[c]); else n_pass++;
            n_checks++; if (a_ls_gnt !== exp_ls[c]) $display("FAIL arb_ls_gnt c%0d: got %b want %b", c, a_ls_gnt, exp_ls[c]); else n_pass++;
            if (c == 2) begin
                n_checks++; if (a_if_rvalid !== exp_if_rv2) $display("FAIL arb_if_rvalid: got %b want %b", a_if_rvalid, exp_if_rv2); else n_pass++;
                n_checks++; if (a_ls_rvalid !== !exp_if_rv2) $display("FAIL arb_ls_rvalid: got %b want %b", a_ls_rvalid, !exp_if_rv2); else n_pass++;
            end
        end
        idle_inputs();
    endtask

    task automatic test_dbg_abort();
        logic stray;
        do_reset();
        dbg_load(32'h40, 32'hCAFE_F00D);
        tick(); ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40;
        @(negedge clock);
        n_checks++; if (b_ls_gnt !== 1'b1) $display("FAIL abort_gnt: got %b want 1", b_ls_gnt); else n_pass++;
        tick();
        @(negedge clock);
        n_checks++; if (b_bus_state !== 2'd2) $display("FAIL abort_wait1: got %0d want 2", b_bus_state); else n_pass++;
        n_checks++; if (b_ls_gnt !== 1'b0) $display("FAIL abort_pending_gnt: got %b want 0", b_ls_gnt); else n_pass++;
        tick(); dbg_wen = 1'b1; dbg_addr = 32'h80; dbg_wdata = 32'h1234_5678;
        @(negedge clock);
        n_checks++; if (b_bus_state !== 2'd2) $display("FAIL abort_wait2: got %0d want 2", b_bus_state); else n_pass++;
        n_checks++; if (b_mem_wen !== 1'b1) $display("FAIL abort_dbg_wen: got %b want 1", b_mem_wen); else n_pass++;
        n_checks++; if (b_mem_wbmask !== 4'hF) $display("FAIL abort_dbg_mask: got %h want f", b_mem_wbmask); else n_pass++;
        n_checks++; if (b_mem_addr !== 32'h80) $display("FAIL abort_dbg_addr: got %h want 80", b_mem_addr); else n_pass++;
        tick(); dbg_wen = 1'b0;
        @(negedge clock);
        n_checks++; if (b_bus_state !== 2'd3) $display("FAIL abort_dbg_state: got %0d want 3", b_bus_state); else n_pass++;
        n_checks++; if (b_ls_gnt !== 1'b0) $display("FAIL abort_dbg_nogrant: got %b want 0", b_ls_gnt); else n_pass++;
        tick();
        @(negedge clock);
        n_checks++; if (b_bus_state !== 2'd0) $display("FAIL abort_back_idle: got %0d want 0", b_bus_state); else n_pass++;
        n_checks++; if (b_ls_gnt !== 1'b1) $display("FAIL abort_regrant: got %b want 1", b_ls_gnt); else n_pass++;
        n_checks++; if (b_ls_rvalid !== 1'b0) $display("FAIL abort_no_rvalid: got %b want 0", b_ls_rvalid); else n_pass++;
        stray = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (c == 0) ls_req = 1'b0;
            @(negedge clock);
            if (b_ls_rvalid !== 1'b0) stray = 1'b1;
        end
        n_checks++; if (stray !== 1'b0) $display("FAIL abort_early_rvalid: got %b want 0", stray); else n_pass++;
        tick();
        @(negedge clock);
        n_checks++; if (b_ls_rvalid !== 1'b1) $display("FAIL regrant_rvalid: got %b want 1", b_ls_rvalid); else n_pass++;
        n_checks++; if (b_ls_rdata !== 32'hCAFE_F00D) $display("FAIL regrant_rdata: got %h want cafef00d", b_ls_rdata); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic stray;
        do_reset();
        tick(); ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40;
        @(negedge clock);
        n_checks++; if (b_ls_gnt !== 1'b1) $display("FAIL rmid_gnt: got %b want 1", b_ls_gnt); else n_pass++;
        tick(); ls_req = 1'b0;
        @(negedge clock);
        n_checks++; if (b_bus_state !== 2'd2) $display("FAIL rmid_wait: got %0d want 2", b_bus_state); else n_pass++;
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (b_bus_state !== 2'd0) $display("FAIL rmid_state: got %0d want 0", b_bus_state); else n_pass++;
        n_checks++; if (b_ls_rvalid !== 1'b0) $display("FAIL rmid_rvalid: got %b want 0", b_ls_rvalid); else n_pass++;
        @(negedge clock);
        reset = 1'b1;
        stray = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            @(negedge clock);
            if (b_ls_rvalid !== 1'b0) stray = 1'b1;
        end
        n_checks++; if (stray !== 1'b0) $display("FAIL rmid_stray_rvalid: got %b want 0", stray); else n_pass++;
        n_checks++; if (b_ls_rdata !== 32'h0) $display("FAIL rmid_rdata: got %h want 0", b_ls_rdata); else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_fetch();
        test_store();
        test_arb();
        test_dbg_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
